// File: rtl/ysyx_22050710_sram_like_slave.sv
// ysyx_22050710_sram_like_slave
// Responder end of the NPC SRAM-like bus. Holds a word-addressed memory and answers
// pipelined requests in order after a fixed LATENCY. Responses are queued (depth OUTSTANDING).
// Optional build macro YSYX_22050710_SLAVE_RAND_STALL_EN: an LFSR randomly withholds addr_ok
// to exercise master-side stall handling; response timing is unaffected.
module ysyx_22050710_sram_like_slave #(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int MEM_AW        = 12,
    parameter int LATENCY       = 2,
    parameter int OUTSTANDING   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic                     i_op,
    input  logic [1:0]               i_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_wdata,
    output logic                     o_addr_ok,
    output logic                     o_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_rdata
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [3:0]       TIMER_INIT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(OUTSTANDING);

    // Reset: asserted asynchronously, released two edges after i_rst_n rises
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Two-flop synchroniser producing the internal reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Memory and response queue storage
    logic [SRAM_DATA_WD-1:0] mem_q   [DEPTH];
    logic [SRAM_DATA_WD-1:0] data_q  [OUTSTANDING];
    logic                    op_q    [OUTSTANDING];
    logic [3:0]              timer_q [OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    full;
    logic                    accept;
    logic                    resp;
    logic [MEM_AW-1:0]       widx;
    logic [SRAM_DATA_WD-1:0] rd_word;

    assign widx    = i_addr[MEM_AW+2:3];
    assign rd_word = mem_q[widx];
    assign full    = (cnt_q == CNT_FULL);

`ifdef YSYX_22050710_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle; bit 0 gates acceptance
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign o_addr_ok = rst_n_int & ~full & lfsr_q[0];
`else
    assign o_addr_ok = rst_n_int & ~full;
`endif

    assign accept    = i_req & o_addr_ok;
    assign resp      = (cnt_q != '0) & (timer_q[rd_ptr_q] == 4'd0);
    assign o_data_ok = resp;
    assign o_rdata   = (resp & ~op_q[rd_ptr_q]) ? data_q[rd_ptr_q] : '0;

    // Next-state for queue pointers and occupancy; push and pop may coincide
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (resp) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(resp);
    end

    // Queue control: pointers, count, per-entry op flag and countdown timers
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                timer_q[i] <= 4'd0;
                op_q[i]    <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (timer_q[i] != 4'd0) begin
                    timer_q[i] <= timer_q[i] - 4'd1;
                end
            end
            if (accept) begin
                timer_q[wr_ptr_q] <= TIMER_INIT;
                op_q[wr_ptr_q]    <= i_op;
            end
        end
    end

    // Response payload: read data is snapshotted at accept, writes answer with zero
    always_ff @(posedge i_clk) begin
        if (accept) begin
            data_q[wr_ptr_q] <= i_op ? '0 : rd_word;
        end
    end

    // Byte-strobed memory write on an accepted write request
    always_ff @(posedge i_clk) begin
        if (accept & i_op) begin
            for (int k = 0; k < SRAM_WMASK_WD; k++) begin
                if (i_wstrb[k]) begin
                    mem_q[widx][k*8 +: 8] <= i_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Size is informational and address bits outside the word index are ignored
    logic unused_bits;
    assign unused_bits = ^{i_size, i_addr[SRAM_ADDR_WD-1:MEM_AW+3], i_addr[2:0]};

endmodule

// File: tb/tb_ysyx_22050710_sram_like_slave.sv
// Testbench for ysyx_22050710_sram_like_slave (default build, LATENCY=2, OUTSTANDING=2).
module tb_ysyx_22050710_sram_like_slave;

    localparam int L   = 2;
    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic        aok;
    logic        dok;
    logic [63:0] rdata;

    always #5 clk = ~clk;

    ysyx_22050710_sram_like_slave #(
        .SRAM_ADDR_WD (32),
        .SRAM_DATA_WD (64),
        .SRAM_WMASK_WD(8),
        .MEM_AW       (12),
        .LATENCY      (L),
        .OUTSTANDING  (OUT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_op     (op),
        .i_size   (size),
        .i_addr   (addr),
        .i_wstrb  (wstrb),
        .i_wdata  (wdata),
        .o_addr_ok(aok),
        .o_data_ok(dok),
        .o_rdata  (rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding responses tagged with the edge number they were accepted on
    typedef struct {
        logic        op;
        logic [63:0] data;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mmem [0:4095];
    int          edge_n = 0;

    typedef struct {
        logic        req;
        logic        op;
        logic [31:0] addr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic        exp_aok;
        logic        exp_dok;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic r, input logic o, input logic [31:0] a,
                                input logic [7:0] s, input logic [63:0] d,
                                input logic ea, input logic ed, input logic [63:0] er);
        vec_t v;
        v.req = r; v.op = o; v.addr = a; v.wstrb = s; v.wdata = d;
        v.exp_aok = ea; v.exp_dok = ed; v.exp_rdata = er;
        return v;
    endfunction

    function automatic bit m_aok();
        return q.size() < OUT;
    endfunction

    function automatic bit m_dok();
        return (q.size() > 0) && (q[0].acc + L - 1 <= edge_n);
    endfunction

    function automatic logic [63:0] m_rdata();
        return m_dok() ? q[0].data : 64'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic o, input logic [31:0] a,
                          input logic [7:0] s, input logic [63:0] d);
        req = r; op = o; addr = a; wstrb = s; wdata = d; size = 2'd3;
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " addr_ok"}, 64'(aok), 64'(m_aok()));
        chk({tag, " data_ok"}, 64'(dok), 64'(m_dok()));
        chk({tag, " rdata"}, rdata, m_rdata());
    endtask

    // Advance one clock and apply the specification's rules to the model
    task automatic tick();
        bit          acc;
        bit          pop;
        int          idx;
        logic [63:0] rd;
        ent_t        e;
        acc = req && m_aok() && rst_n;
        pop = m_dok();
        idx = int'((addr >> 3) % 32'd4096);
        rd  = mmem[idx];
        @(posedge clk);
        if (pop) e = q.pop_front();
        edge_n++;
        if (acc) begin
            if (op) begin
                for (int k = 0; k < 8; k++)
                    if (wstrb[k]) mmem[idx][k*8 +: 8] = wdata[k*8 +: 8];
            end
            e.op   = op;
            e.data = op ? 64'd0 : rd;
            e.acc  = edge_n;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] R, W2, M2, D;
        int          acc3, ndok, aok_at2;
        logic [31:0] a;

        R  = 64'h1122334455667788;
        W2 = 64'hFFFFFFFF_AAAABBBB;
        M2 = 64'h11223344_AAAABBBB;
        D  = 64'hDEADBEEF_CAFEF00D;

        vt[0]  = mk(1, 1, 32'h28,        8'hFF, R,  1, 0, 0);
        vt[1]  = mk(0, 0, 0,             0,     0,  1, 0, 0);
        vt[2]  = mk(0, 0, 0,             0,     0,  1, 1, 0);
        vt[3]  = mk(1, 0, 32'h28,        0,     0,  1, 0, 0);
        vt[4]  = mk(0, 0, 0,             0,     0,  1, 0, 0);
        vt[5]  = mk(0, 0, 0,             0,     0,  1, 1, R);
        vt[6]  = mk(1, 1, 32'h28,        8'h0F, W2, 1, 0, 0);
        vt[7]  = mk(1, 0, 32'h28,        0,     0,  1, 0, 0);
        vt[8]  = mk(0, 0, 0,             0,     0,  0, 1, 0);
        vt[9]  = mk(0, 0, 0,             0,     0,  1, 1, M2);
        vt[10] = mk(1, 1, 32'h8000_0028, 8'hFF, D,  1, 0, 0);
        vt[11] = mk(1, 0, 32'h28,        0,     0,  1, 0, 0);
        vt[12] = mk(0, 0, 0,             0,     0,  0, 1, 0);
        vt[13] = mk(0, 0, 0,             0,     0,  1, 1, D);
        vt[14] = mk(1, 1, 32'h28,        8'h00, 0,  1, 0, 0);
        vt[15] = mk(1, 0, 32'h8000_0028, 0,     0,  1, 0, 0);
        vt[16] = mk(0, 0, 0,             0,     0,  0, 1, 0);
        vt[17] = mk(0, 0, 0,             0,     0,  1, 1, D);
        vt[18] = mk(0, 0, 0,             0,     0,  1, 0, 0);

        // Reset state
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset addr_ok", 64'(aok), 64'd0);
        chk("reset data_ok", 64'(dok), 64'd0);
        chk("reset rdata", rdata, 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        cmp_model("post-reset");

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            set_in(vt[i].req, vt[i].op, vt[i].addr, vt[i].wstrb, vt[i].wdata);
            chk($sformatf("vec%0d addr_ok", i), 64'(aok), 64'(vt[i].exp_aok));
            chk($sformatf("vec%0d data_ok", i), 64'(dok), 64'(vt[i].exp_dok));
            chk($sformatf("vec%0d rdata", i), rdata, vt[i].exp_rdata);
            tick();
        end

        // Held request, four reads into a two-deep queue
        acc3 = 0; ndok = 0; aok_at2 = -1;
        for (int c = 0; c < 20; c++) begin
            set_in(acc3 < 4, 0, 32'h28 + 32'(acc3 * 4096 * 8), 0, 0);
            if (c == 2) aok_at2 = int'(aok);
            if (dok) ndok++;
            cmp_model($sformatf("burst c%0d", c));
            if (req && aok) acc3++;
            tick();
        end
        chk("burst accepted", 64'(acc3), 64'd4);
        chk("burst full stall", 64'(aok_at2), 64'd0);
        chk("burst responses", 64'(ndok), 64'd4);

        // Reset with a read in flight
        set_in(1, 0, 32'h28, 0, 0);
        cmp_model("inflight accept");
        tick();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("inflight rst addr_ok", 64'(aok), 64'd0);
        chk("inflight rst data_ok", 64'(dok), 64'd0);
        chk("inflight rst rdata", rdata, 64'd0);
        tick();
        chk("inflight rst data_ok c1", 64'(dok), 64'd0);
        tick();
        chk("inflight rst data_ok c2", 64'(dok), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("inflight rel data_ok", 64'(dok), 64'd0);
        tick();
        tick();
        cmp_model("inflight after reset");

        // Random traffic over 16 pre-initialised words
        for (int w = 0; w < 16; w++) begin
            a = $urandom;
            a[14:3] = 12'(w);
            set_in(1, 1, a, 8'hFF, {$urandom, $urandom});
            cmp_model($sformatf("init w%0d", w));
            if (aok) tick();
            else begin
                tick();
                w--;
            end
        end
        for (int c = 0; c < 400; c++) begin
            a = $urandom;
            a[14:3] = 12'($urandom_range(0, 15));
            set_in($urandom_range(0, 3) != 0, 1'($urandom), a, 8'($urandom), {$urandom, $urandom});
            cmp_model($sformatf("rand c%0d", c));
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            cmp_model($sformatf("drain c%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
